// File: rtl/booth2_arb_pkg.sv
// Shared definitions for the Booth2 sharing arbiter: FSM encoding, default sizes
// and a clog2 helper used for parameter sanity checks.
package booth2_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } arb_state_t;

    localparam int unsigned DEF_WIDTH     = 32;
    localparam int unsigned DEF_MC_CYCLES = 2;

    function automatic int unsigned f_clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = (n > 0) ? n - 1 : 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/Booth2.sv
// Combinational radix-4 Booth multiplier: SUM = X * Y, both operands two's complement.
module Booth2 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic signed [WIDTH-1:0]   Y,
    input  logic signed [WIDTH-1:0]   X,
    output logic signed [2*WIDTH-1:0] SUM
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned NG = (WIDTH + 1) / 2;

    logic [2*NG:0]  w_y_ext;
    logic [PW-1:0]  w_x_ext;
    logic [PW-1:0]  w_pp;
    logic [PW-1:0]  w_acc;

    // Multiplier gets an implicit 0 below the LSB; odd widths need one extra sign bit.
    generate
        if (2 * NG == WIDTH) begin : g_even
            assign w_y_ext = {Y, 1'b0};
        end else begin : g_odd
            assign w_y_ext = {Y[WIDTH-1], Y, 1'b0};
        end
    endgenerate

    assign w_x_ext = {{WIDTH{X[WIDTH-1]}}, X};

    always_comb begin
        w_acc = '0;
        w_pp  = '0;
        for (int j = 0; j < int'(NG); j++) begin
            case (w_y_ext[2*j +: 3])
                3'b001, 3'b010: w_pp = w_x_ext;
                3'b011:         w_pp = w_x_ext << 1;
                3'b100:         w_pp = -(w_x_ext << 1);
                3'b101, 3'b110: w_pp = -w_x_ext;
                default:        w_pp = '0;
            endcase
            w_acc = w_acc + (w_pp << (2 * j));
        end
    end

    assign SUM = $signed(w_acc);

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid requester strictly after i_ptr, wrapping.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] i_valid,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_idx,
    output logic            o_any
);

    // Upper pass covers indices above the pointer; lower pass handles the wrap.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!o_any && i_valid[i] && (IDW'(i) > i_ptr)) begin
                o_any      = 1'b1;
                o_grant[i] = 1'b1;
                o_idx      = IDW'(i);
            end
        end
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!o_any && i_valid[i]) begin
                o_any      = 1'b1;
                o_grant[i] = 1'b1;
                o_idx      = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/booth2_share_arb.sv
// Round-robin sharing of one Booth2 multiplier among NREQ requesters with a
// multicycle settle window. Optional self-check built under BOOTH2_ARB_CHECK_EN.
module booth2_share_arb
    import booth2_arb_pkg::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned MC_CYCLES = DEF_MC_CYCLES,
    parameter int unsigned IDW       = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [2*WIDTH-1:0]    rsp_prod,
    output logic                  busy,
    output logic                  chk_err
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = (MC_CYCLES > 1) ? f_clog2(MC_CYCLES) : 1;

    generate
        if (IDW < f_clog2(NREQ)) begin : g_bad_idw
            $error("booth2_share_arb: IDW too small for NREQ");
        end
    endgenerate

    arb_state_t      r_state;
    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  r_cur_id;
    logic [CW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_op_x;
    logic [WIDTH-1:0] r_op_y;
    logic            r_rsp_valid;
    logic [IDW-1:0]  r_rsp_id;
    logic [PW-1:0]   r_rsp_prod;
    logic            r_busy;

    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_idx;
    logic            w_any;
    logic            w_open;
    logic            w_accept;
    logic            w_capture;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic [PW-1:0]   w_sum;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .i_valid (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // Grants are only offered when the multiplier is free; reset suppresses any accept.
    assign w_open    = !rst && ((r_state == ST_IDLE) || ((r_state == ST_HOLD) && rsp_ready));
    assign w_accept  = w_open && w_any;
    assign req_ready = w_open ? w_grant : '0;
    assign w_capture = (r_state == ST_WAIT) && (r_cnt == '0);

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (w_grant[i]) begin
                w_sel_a = req_a[i*WIDTH +: WIDTH];
                w_sel_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    Booth2 #(
        .WIDTH (WIDTH)
    ) u_booth2 (
        .Y   (r_op_y),
        .X   (r_op_x),
        .SUM (w_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= IDW'(NREQ - 1);
            r_cur_id    <= '0;
            r_cnt       <= '0;
            r_op_x      <= '0;
            r_op_y      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_prod  <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op_x   <= w_sel_a;
                        r_op_y   <= w_sel_b;
                        r_cur_id <= w_idx;
                        r_ptr    <= w_idx;
                        r_cnt    <= CW'(MC_CYCLES - 1);
                        r_state  <= ST_WAIT;
                        r_busy   <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_rsp_prod  <= w_sum;
                        r_rsp_id    <= r_cur_id;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_HOLD;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_HOLD: begin
                    // Retiring the response and accepting the next request share one edge.
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        if (w_accept) begin
                            r_op_x   <= w_sel_a;
                            r_op_y   <= w_sel_b;
                            r_cur_id <= w_idx;
                            r_ptr    <= w_idx;
                            r_cnt    <= CW'(MC_CYCLES - 1);
                            r_state  <= ST_WAIT;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_prod  = r_rsp_prod;
    assign busy      = r_busy;

`ifdef BOOTH2_ARB_CHECK_EN
    logic signed [PW-1:0] w_ref_x;
    logic signed [PW-1:0] w_ref_y;
    logic signed [PW-1:0] w_ref;
    logic                 r_chk_err;

    assign w_ref_x = $signed({{WIDTH{r_op_x[WIDTH-1]}}, r_op_x});
    assign w_ref_y = $signed({{WIDTH{r_op_y[WIDTH-1]}}, r_op_y});
    assign w_ref   = w_ref_x * w_ref_y;

    // Sticky compare of the Booth result against a plain multiply at capture time.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_chk_err <= 1'b0;
        end else if (w_capture && (w_sum != $unsigned(w_ref))) begin
            r_chk_err <= 1'b1;
`ifndef SYNTHESIS
            $display("booth2_share_arb: self-check error id=%0d x=%0h y=%0h got=%0h ref=%0h",
                     r_cur_id, r_op_x, r_op_y, w_sum, w_ref);
`endif
        end
    end

    assign chk_err = r_chk_err;
`else
    logic w_capture_unused;
    assign w_capture_unused = w_capture;
    assign chk_err          = 1'b0;
`endif

endmodule

// File: tb/tb_booth2_share_arb.sv
// Self-checking bench for booth2_share_arb: directed tables plus a randomized run
// compared every cycle against a transaction-level reference model.
module tb_booth2_share_arb;

    localparam int NREQ  = 4;
    localparam int WIDTH = 32;
    localparam int MC    = 2;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [2*WIDTH-1:0]    rsp_prod;
    logic                  busy;
    logic                  chk_err;

    booth2_share_arb #(
        .NREQ      (NREQ),
        .WIDTH     (WIDTH),
        .MC_CYCLES (MC),
        .IDW       (IDW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_prod  (rsp_prod),
        .busy      (busy),
        .chk_err   (chk_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail_tmo(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out waiting (t=%0t)", nm, $time);
    endtask

    // Reference model: one multiply in flight; response shows MC edges after accept.
    int      m_ptr;
    bit      m_pending;
    bit      m_shown;
    int      m_due;
    int      m_id;
    longint  m_prod;
    int      acc_cnt [NREQ];
    int      rsp_cnt [NREQ];

    function automatic int rr_winner(input logic [NREQ-1:0] v, input int p);
        for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (p + k) % NREQ;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    always @(negedge clk) begin
        int               w;
        logic [NREQ-1:0]  er;
        int               a_op;
        int               b_op;
        if (rst) begin
            m_ptr     = NREQ - 1;
            m_pending = 1'b0;
            m_shown   = 1'b0;
            m_due     = 0;
            m_id      = 0;
            m_prod    = 0;
        end else begin
            w  = (!m_pending || (m_shown && rsp_ready)) ? rr_winner(req_valid, m_ptr) : -1;
            er = '0;
            if (w >= 0) er[w] = 1'b1;
            chk("req_ready", 64'(req_ready), 64'(er));
            chk("rsp_valid", 64'(rsp_valid), 64'(m_shown));
            chk("busy", 64'(busy), 64'(m_pending));
            chk("chk_err", 64'(chk_err), 64'd0);
            if (m_shown) begin
                chk("rsp_id", 64'(rsp_id), 64'(m_id));
                chk("rsp_prod", rsp_prod, m_prod);
            end
            if (|(req_ready & req_valid)) acc_cnt[onehot_idx(req_ready & req_valid)]++;
            if (rsp_valid && rsp_ready) rsp_cnt[rsp_id]++;
            if (m_pending) begin
                if (m_shown) begin
                    if (rsp_ready) begin
                        m_pending = 1'b0;
                        m_shown   = 1'b0;
                    end
                end else begin
                    m_due--;
                    if (m_due == 0) m_shown = 1'b1;
                end
            end
            if (w >= 0) begin
                a_op      = req_a[w*WIDTH +: WIDTH];
                b_op      = req_b[w*WIDTH +: WIDTH];
                m_pending = 1'b1;
                m_shown   = 1'b0;
                m_due     = MC;
                m_id      = w;
                m_prod    = longint'(a_op) * longint'(b_op);
                m_ptr     = w;
            end
        end
    end

    task automatic set_req(input int id, input int a, input int b);
        req_a[id*WIDTH +: WIDTH] = a;
        req_b[id*WIDTH +: WIDTH] = b;
        req_valid[id]            = 1'b1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst       = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Single request; returns latency in cycles from the accept cycle to rsp_valid.
    task automatic do_req(input int id, input int a, input int b,
                          output int lat, output longint prod, output int rid);
        int t;
        lat  = 0;
        prod = 0;
        rid  = -1;
        set_req(id, a, b);
        t = 0;
        @(negedge clk);
        while (!req_ready[id] && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready[id]) begin
            fail_tmo("do_req_accept");
            req_valid[id] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        lat = 1;
        t   = 0;
        @(negedge clk);
        while (!rsp_valid && t < 50) begin
            @(posedge clk); #1;
            lat++;
            @(negedge clk);
            t++;
        end
        if (!rsp_valid) begin
            fail_tmo("do_req_rsp");
            return;
        end
        prod = rsp_prod;
        rid  = int'(rsp_id);
        @(posedge clk); #1;
    endtask

    typedef struct {
        int     id;
        int     a;
        int     b;
        longint exp;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int     lat;
        longint prod;
        int     rid;
        int     order [6];
        int     exp_order [6];
        int     n;
        int     t;
        int     accepts;
        logic [NREQ-1:0] got;

        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int     lat;
        longint prod;
        int     rid;
        int     order [6];
        int     exp_order [6];
        int     n;
        int     t;
        int     accepts;
        int     ra;
        int     rb;
        logic [NREQ-1:0] got;

        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            acc_cnt[i] = 0;
            rsp_cnt[i] = 0;
        end

        tbl[0] = '{0, 12345, -678, -64'sd8369910};
        tbl[1] = '{1, 32'sh8000_0000, 32'sh8000_0000, 64'sh4000_0000_0000_0000};
        tbl[2] = '{2, 32'sh7FFF_FFFF, 32'sh8000_0000, -64'sd4611686016279904256};
        tbl[3] = '{3, 0, -12345, 64'sd0};
        tbl[4] = '{0, -1, -1, 64'sd1};
        tbl[5] = '{2, -1, 1, -64'sd1};
        tbl[6] = '{1, 7, -3, -64'sd21};
        tbl[7] = '{3, 32'sh7FFF_FFFF, 32'sh7FFF_FFFF, 64'sh3FFF_FFFF_0000_0001};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        @(negedge clk);
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_id", 64'(rsp_id), 64'd0);
        chk("reset_rsp_prod", rsp_prod, 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_chk_err", 64'(chk_err), 64'd0);
        @(posedge clk); #1;

        // Directed single requests, including arithmetic extremes.
        for (int v = 0; v < 8; v++) begin
            do_req(tbl[v].id, tbl[v].a, tbl[v].b, lat, prod, rid);
            chk($sformatf("tbl%0d_prod", v), prod, tbl[v].exp);
            chk($sformatf("tbl%0d_id", v), 64'(rid), 64'(tbl[v].id));
            chk($sformatf("tbl%0d_latency", v), 64'(lat), 64'(MC + 1));
        end

        // Contention fairness from a fresh pointer.
        do_reset();
        exp_order = '{0, 1, 2, 3, 0, 1};
        for (int i = 0; i < NREQ; i++) set_req(i, i * 1000 - 1500, i - 7);
        n = 0;
        t = 0;
        while (n < 6 && t < 100) begin
            @(negedge clk);
            if (|req_ready) begin
                order[n] = onehot_idx(req_ready);
                n++;
            end
            @(posedge clk); #1;
            t++;
        end
        if (n < 6) fail_tmo("fair_grants");
        for (int k = 0; k < n; k++) chk($sformatf("fair_order%0d", k), 64'(order[k]), 64'(exp_order[k]));
        req_valid = '0;
        repeat (8) @(posedge clk);
        #1;

        // Backpressure: response held while rsp_ready is low, then back-to-back accept.
        do_reset();
        rsp_ready = 1'b0;
        set_req(1, -5, 9);
        t = 0;
        @(negedge clk);
        while (!req_ready[1] && t < 50) begin @(negedge clk); t++; end
        if (!req_ready[1]) fail_tmo("bp_accept");
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        set_req(2, 6, -7);
        t = 0;
        @(negedge clk);
        while (!rsp_valid && t < 50) begin @(negedge clk); t++; end
        if (!rsp_valid) fail_tmo("bp_rsp");
        for (int k = 0; k < 5; k++) begin
            chk("bp_prod", rsp_prod, -64'sd45);
            chk("bp_id", 64'(rsp_id), 64'd1);
            chk("bp_ready_low", 64'(req_ready), 64'd0);
            @(posedge clk); #1;
            if (k == 4) rsp_ready = 1'b1;
            @(negedge clk);
        end
        chk("bp_next_accept", 64'(req_ready), 64'b0100);
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        t = 0;
        @(negedge clk);
        while (!rsp_valid && t < 50) begin @(negedge clk); t++; end
        if (!rsp_valid) fail_tmo("bp_rsp2");
        chk("bp2_prod", rsp_prod, -64'sd42);
        chk("bp2_id", 64'(rsp_id), 64'd2);
        @(posedge clk); #1;

        // Reset one cycle after an accept discards the pending response.
        set_req(0, 77, 88);
        t = 0;
        @(negedge clk);
        while (!req_ready[0] && t < 50) begin @(negedge clk); t++; end
        if (!req_ready[0]) fail_tmo("rst_accept");
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("rst_no_rsp", 64'(rsp_valid), 64'd0);
        end
        @(posedge clk); #1;
        do_req(2, -31, 1001, lat, prod, rid);
        chk("rst_req2_prod", prod, -64'sd31031);
        chk("rst_req2_id", 64'(rid), 64'd2);

        // Random regression.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            acc_cnt[i] = 0;
            rsp_cnt[i] = 0;
        end
        accepts = 0;
        for (int cyc = 0; cyc < 20000 && accepts < 1000; cyc++) begin
            @(negedge clk);
            got = req_ready & req_valid;
            if (|got) accepts++;
            @(posedge clk); #1;
            for (int i = 0; i < NREQ; i++) begin
                if (got[i]) begin
                    req_valid[i] = 1'b0;
                end else if (!req_valid[i]) begin
                    if ($urandom_range(1, 0) == 1) begin
                        case ($urandom_range(7, 0))
                            0: ra = 32'sh8000_0000;
                            1: ra = 32'sh7FFF_FFFF;
                            2: ra = 0;
                            default: ra = int'($urandom());
                        endcase
                        case ($urandom_range(7, 0))
                            0: rb = 32'sh8000_0000;
                            1: rb = -1;
                            default: rb = int'($urandom());
                        endcase
                        set_req(i, ra, rb);
                    end
                end else if ($urandom_range(15, 0) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(3, 0) != 0);
        end
        if (accepts < 1000) fail_tmo("random_accepts");
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        @(negedge clk);
        chk("drain_idle", 64'(busy), 64'd0);
        for (int i = 0; i < NREQ; i++)
            chk($sformatf("count_req%0d", i), 64'(rsp_cnt[i]), 64'(acc_cnt[i]));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
